// File: rtl/rggen_host_access_controller.sv
// Host-side access controller: accepts one host command, broadcasts it to the register
// slots, waits for the selected slot to complete (or time out) and returns a response.
module rggen_host_access_controller #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_command_valid,
    output logic                            o_command_ready,
    input  logic                            i_write,
    input  logic [ADDRESS_WIDTH-1:0]        i_address,
    input  logic [DATA_WIDTH-1:0]           i_write_data,
    input  logic [DATA_WIDTH/8-1:0]         i_strobe,
    output logic                            o_response_valid,
    input  logic                            i_response_ready,
    output logic [DATA_WIDTH-1:0]           o_read_data,
    output logic [1:0]                      o_status,
    output logic                            o_register_valid,
    output logic                            o_register_write,
    output logic [ADDRESS_WIDTH-1:0]        o_register_address,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]            i_register_select,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int COUNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? COUNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] STATUS_OKAY    = 2'b00;
    localparam logic [1:0] STATUS_ERROR   = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [COUNT_WIDTH-1:0]   wait_count;
    logic [COUNT_WIDTH-1:0]   wait_count_next;
    logic [DATA_WIDTH-1:0]    response_data;
    logic [DATA_WIDTH-1:0]    response_data_next;
    logic [1:0]               response_status;
    logic [1:0]               response_status_next;

    logic                     captured_write;
    logic [ADDRESS_WIDTH-1:0] captured_address;
    logic [DATA_WIDTH-1:0]    captured_write_data;
    logic [STROBE_WIDTH-1:0]  captured_strobe;

    logic                     select_any;
    logic                     select_one;
    logic                     selected_ready;
    logic [DATA_WIDTH-1:0]    selected_data;
    logic                     timeout_hit;

    // A single set bit clears to zero when ANDed with itself minus one.
    always_comb begin
        select_any     = |i_register_select;
        select_one     = select_any &&
                         ((i_register_select & (i_register_select - REGISTERS'(1))) == '0);
        selected_ready = |(i_register_select & i_register_ready);
        selected_data  = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_register_select[k]) begin
                selected_data = selected_data | i_register_read_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_count == TIMEOUT_LAST);
    end

    always_comb begin
        state_next           = state;
        wait_count_next      = wait_count;
        response_data_next   = response_data;
        response_status_next = response_status;
        case (state)
            IDLE: begin
                if (i_command_valid) begin
                    state_next      = ACCESS;
                    wait_count_next = '0;
                end
            end
            ACCESS: begin
                if (!select_one) begin
                    state_next           = RESPOND;
                    response_data_next   = '0;
                    response_status_next = STATUS_ERROR;
                end else if (selected_ready) begin
                    state_next           = RESPOND;
                    response_data_next   = captured_write ? '0 : selected_data;
                    response_status_next = STATUS_OKAY;
                end else if (timeout_hit) begin
                    state_next           = RESPOND;
                    response_data_next   = '0;
                    response_status_next = STATUS_TIMEOUT;
                end else begin
                    wait_count_next = wait_count + COUNT_WIDTH'(1);
                end
            end
            RESPOND: begin
                if (i_response_ready) begin
                    state_next           = IDLE;
                    response_data_next   = '0;
                    response_status_next = STATUS_OKAY;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            wait_count          <= '0;
            response_data       <= '0;
            response_status     <= STATUS_OKAY;
            captured_write      <= 1'b0;
            captured_address    <= '0;
            captured_write_data <= '0;
            captured_strobe     <= '0;
        end else begin
            state           <= state_next;
            wait_count      <= wait_count_next;
            response_data   <= response_data_next;
            response_status <= response_status_next;
            if ((state == IDLE) && i_command_valid) begin
                captured_write      <= i_write;
                captured_address    <= i_address;
                captured_write_data <= i_write_data;
                captured_strobe     <= i_strobe;
            end
        end
    end

    always_comb begin
        o_command_ready       = (state == IDLE);
        o_response_valid      = (state == RESPOND);
        o_read_data           = o_response_valid ? response_data : '0;
        o_status              = o_response_valid ? response_status : STATUS_OKAY;
        o_register_valid      = (state == ACCESS);
        o_register_write      = captured_write;
        o_register_address    = captured_address;
        o_register_write_data = captured_write_data;
        o_register_strobe     = captured_strobe;
    end

endmodule

// File: tb/tb_rggen_host_access_controller.sv
// Directed bench for rggen_host_access_controller with four slots and a short timeout.
module tb_rggen_host_access_controller;

    logic         clk;
    logic         rst;
    logic         i_command_valid;
    logic         o_command_ready;
    logic         i_write;
    logic [15:0]  i_address;
    logic [31:0]  i_write_data;
    logic [3:0]   i_strobe;
    logic         o_response_valid;
    logic         i_response_ready;
    logic [31:0]  o_read_data;
    logic [1:0]   o_status;
    logic         o_register_valid;
    logic         o_register_write;
    logic [15:0]  o_register_address;
    logic [31:0]  o_register_write_data;
    logic [3:0]   o_register_strobe;
    logic [3:0]   i_register_select;
    logic [3:0]   i_register_ready;
    logic [127:0] i_register_read_data;

    logic [3:0]   ready_mask;
    int           ready_delay;
    int           access_count;
    int           total_checks;
    int           passed_checks;

    typedef struct {
        logic        write;
        logic [15:0] address;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        logic [3:0]  select;
        logic [3:0]  ready_mask;
        int          ready_delay;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[9];

    rggen_host_access_controller #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .REGISTERS     (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_command_valid      (i_command_valid),
        .o_command_ready      (o_command_ready),
        .i_write              (i_write),
        .i_address            (i_address),
        .i_write_data         (i_write_data),
        .i_strobe             (i_strobe),
        .o_response_valid     (o_response_valid),
        .i_response_ready     (i_response_ready),
        .o_read_data          (o_read_data),
        .o_status             (o_status),
        .o_register_valid     (o_register_valid),
        .o_register_write     (o_register_write),
        .o_register_address   (o_register_address),
        .o_register_write_data(o_register_write_data),
        .o_register_strobe    (o_register_strobe),
        .i_register_select    (i_register_select),
        .i_register_ready     (i_register_ready),
        .i_register_read_data (i_register_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_register_read_data = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    // Slot model: raises its ready bits once the access has lasted ready_delay cycles.
    always @(posedge clk) begin
        if (o_register_valid) access_count <= access_count + 1;
        else                  access_count <= 0;
    end
    assign i_register_ready = (o_register_valid && (access_count >= ready_delay)) ? ready_mask : 4'b0000;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic issueCommand(input vec_t v);
        @(negedge clk);
        i_write           = v.write;
        i_address         = v.address;
        i_write_data      = v.wdata;
        i_strobe          = v.strobe;
        i_register_select = v.select;
        ready_mask        = v.ready_mask;
        ready_delay       = v.ready_delay;
        i_response_ready  = 1'b0;
        i_command_valid   = 1'b1;
        checkOutput("command_ready_idle", {31'd0, o_command_ready}, 32'd1);
        @(negedge clk);
        i_command_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int cycles;
        issueCommand(v);
        cycles = 0;
        checkOutput($sformatf("v%0d_reg_valid", idx), {31'd0, o_register_valid}, 32'd1);
        checkOutput($sformatf("v%0d_reg_write", idx), {31'd0, o_register_write}, {31'd0, v.write});
        checkOutput($sformatf("v%0d_reg_address", idx), {16'd0, o_register_address}, {16'd0, v.address});
        checkOutput($sformatf("v%0d_reg_wdata", idx), o_register_write_data, v.wdata);
        checkOutput($sformatf("v%0d_reg_strobe", idx), {28'd0, o_register_strobe}, {28'd0, v.strobe});
        while (!o_response_valid && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput($sformatf("v%0d_access_cycles", idx), cycles, v.exp_cycles);
        checkOutput($sformatf("v%0d_status", idx), {30'd0, o_status}, {30'd0, v.exp_status});
        checkOutput($sformatf("v%0d_read_data", idx), o_read_data, v.exp_data);
        checkOutput($sformatf("v%0d_reg_valid_off", idx), {31'd0, o_register_valid}, 32'd0);
        i_response_ready = 1'b1;
        @(negedge clk);
        i_response_ready  = 1'b0;
        i_register_select = 4'b0000;
        checkOutput($sformatf("v%0d_resp_valid_after", idx), {31'd0, o_response_valid}, 32'd0);
        checkOutput($sformatf("v%0d_data_idle", idx), o_read_data, 32'd0);
        checkOutput($sformatf("v%0d_status_idle", idx), {30'd0, o_status}, 32'd0);
        checkOutput($sformatf("v%0d_command_ready_after", idx), {31'd0, o_command_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h0008, 32'h0, 4'hF, 4'b0100, 4'b0100, 0,  2'b00, 32'hCAFE0002, 1};
        vecs[1] = '{1'b1, 16'h0100, 32'h12345678, 4'hF, 4'b0000, 4'b0000, 0, 2'b01, 32'h0, 1};
        vecs[2] = '{1'b0, 16'h0000, 32'h0, 4'hF, 4'b0001, 4'b0001, 2,  2'b00, 32'hCAFE0000, 3};
        vecs[3] = '{1'b0, 16'h0004, 32'h0, 4'hF, 4'b0010, 4'b0010, 99, 2'b10, 32'h0, 4};
        vecs[4] = '{1'b0, 16'h000C, 32'h0, 4'hF, 4'b1000, 4'b1000, 3,  2'b00, 32'hCAFE0003, 4};
        vecs[5] = '{1'b0, 16'h0004, 32'h0, 4'hF, 4'b0011, 4'b0011, 0,  2'b01, 32'h0, 1};
        vecs[6] = '{1'b1, 16'h0004, 32'hA5A5_5A5A, 4'h3, 4'b0010, 4'b0010, 0, 2'b00, 32'h0, 1};
        vecs[7] = '{1'b0, 16'h0008, 32'h0, 4'hF, 4'b0100, 4'b1011, 0,  2'b10, 32'h0, 4};
        vecs[8] = '{1'b0, 16'h000C, 32'h0, 4'h0, 4'b1000, 4'b1000, 1,  2'b00, 32'hCAFE0003, 2};

        total_checks      = 0;
        passed_checks     = 0;
        rst               = 1'b1;
        i_command_valid   = 1'b0;
        i_write           = 1'b0;
        i_address         = '0;
        i_write_data      = '0;
        i_strobe          = '0;
        i_response_ready  = 1'b0;
        i_register_select = '0;
        ready_mask        = '0;
        ready_delay       = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_resp_valid", {31'd0, o_response_valid}, 32'd0);
        checkOutput("reset_read_data", o_read_data, 32'd0);
        checkOutput("reset_status", {30'd0, o_status}, 32'd0);
        checkOutput("reset_reg_valid", {31'd0, o_register_valid}, 32'd0);
        checkOutput("reset_reg_address", {16'd0, o_register_address}, 32'd0);
        checkOutput("reset_reg_wdata", o_register_write_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_command_ready", {31'd0, o_command_ready}, 32'd1);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        // Held-off response: payload must stay put and a pending command must not slip in.
        issueCommand(vecs[0]);
        @(negedge clk);
        i_command_valid = 1'b1;
        i_address       = 16'h000C;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("hold%0d_resp_valid", c), {31'd0, o_response_valid}, 32'd1);
            checkOutput($sformatf("hold%0d_read_data", c), o_read_data, 32'hCAFE0002);
            checkOutput($sformatf("hold%0d_status", c), {30'd0, o_status}, 32'd0);
            checkOutput($sformatf("hold%0d_command_ready", c), {31'd0, o_command_ready}, 32'd0);
            checkOutput($sformatf("hold%0d_reg_valid", c), {31'd0, o_register_valid}, 32'd0);
            @(negedge clk);
        end
        i_command_valid  = 1'b0;
        i_response_ready = 1'b1;
        @(negedge clk);
        i_response_ready = 1'b0;
        checkOutput("hold_released_reg_valid", {31'd0, o_register_valid}, 32'd0);
        checkOutput("hold_released_command_ready", {31'd0, o_command_ready}, 32'd1);
        checkOutput("hold_released_resp_valid", {31'd0, o_response_valid}, 32'd0);

        // Reset in the middle of a stalled access abandons the command.
        issueCommand(vecs[3]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_reg_valid", {31'd0, o_register_valid}, 32'd0);
        checkOutput("midrst_reg_address", {16'd0, o_register_address}, 32'd0);
        checkOutput("midrst_resp_valid", {31'd0, o_response_valid}, 32'd0);
        checkOutput("midrst_status", {30'd0, o_status}, 32'd0);
        checkOutput("midrst_command_ready", {31'd0, o_command_ready}, 32'd1);
        rst = 1'b0;
        i_register_select = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst_quiet%0d", c), {30'd0, o_response_valid, o_register_valid}, 32'd0);
        end

        applyStimulus(vecs[0], 9);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
